// File: rtl/interp_lut_loader_if.sv
// interp_lut_loader_if: start/stream/LUT-write bundle between a coefficient source and the LUT loader.
interface interp_lut_loader_if #(
    parameter int LUT_bits     = 26,
    parameter int LUT_addWidth = 11,
    parameter int p            = 1,
    parameter int AW           = LUT_addWidth + p
);
    logic                start_i;
    logic [1:0]          func_i;
    logic                s_valid_i;
    logic [LUT_bits-1:0] s_data_i;
    logic                s_last_i;
    logic                s_ready_o;
    logic                wr_en_o;
    logic [1:0]          wr_func_o;
    logic [AW-1:0]       wr_addr_o;
    logic [LUT_bits-1:0] wr_data_o;
    logic                busy_o;
    logic                done_o;
    logic                err_o;
    logic [LUT_bits-1:0] checksum_o;
    modport slave (
        input  start_i, func_i, s_valid_i, s_data_i, s_last_i,
        output s_ready_o, wr_en_o, wr_func_o, wr_addr_o, wr_data_o, busy_o, done_o, err_o, checksum_o
    );
    modport master (
        output start_i, func_i, s_valid_i, s_data_i, s_last_i,
        input  s_ready_o, wr_en_o, wr_func_o, wr_addr_o, wr_data_o, busy_o, done_o, err_o, checksum_o
    );
endinterface

// File: rtl/interp_lut_loader.sv
// interp_lut_loader: writes a segment-major coefficient stream into the selected interpolation LUT
// and verifies the trailing checksum word.
module interp_lut_loader #(
    parameter int LUT_bits     = 26,
    parameter int LUT_addWidth = 11,
    parameter int p            = 1,
    parameter int AW           = LUT_addWidth + p
) (
    input logic                CLK,
    input logic                nRST,
    interp_lut_loader_if.slave bus
);
    localparam int KW = (p > 0) ? $clog2(p + 1) : 1;
    typedef enum logic [1:0] {IDLE, LOAD, CHECK} state_t;
    state_t              state_q;
    logic [1:0]          func_q;
    logic [LUT_addWidth-1:0] seg_q;
    logic [KW-1:0]       k_q;
    logic [LUT_bits-1:0] checksum_q;
    logic                wr_en_q;
    logic [AW-1:0]       wr_addr_q;
    logic [LUT_bits-1:0] wr_data_q;
    logic                done_q;
    logic                err_q;
    logic                ready;
    logic                accept;
    logic                csum_ok;
    logic [LUT_bits-1:0] checksum_d;
    logic [AW-1:0]       addr_d;
    assign ready      = state_q != IDLE;
    assign accept     = bus.s_valid_i && ready;
    assign csum_ok    = bus.s_last_i && (bus.s_data_i == checksum_q);
    assign checksum_d = checksum_q + bus.s_data_i;
    // coefficient index k selects the table bank, segment is the low address part
    assign addr_d     = (AW'(k_q) << LUT_addWidth) | AW'(seg_q);
    assign bus.s_ready_o  = ready;
    assign bus.busy_o     = ready;
    assign bus.wr_en_o    = wr_en_q;
    assign bus.wr_func_o  = func_q;
    assign bus.wr_addr_o  = wr_addr_q;
    assign bus.wr_data_o  = wr_data_q;
    assign bus.done_o     = done_q;
    assign bus.err_o      = err_q;
    assign bus.checksum_o = checksum_q;
    always_ff @(posedge CLK) begin
        wr_en_q <= 1'b0;
        done_q  <= 1'b0;
        err_q   <= 1'b0;
        if (!nRST) begin
            state_q    <= IDLE;
            func_q     <= '0;
            seg_q      <= '0;
            k_q        <= '0;
            checksum_q <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (bus.start_i) begin
                    if (bus.func_i == 2'd3) err_q <= 1'b1;
                    else begin
                        func_q     <= bus.func_i;
                        seg_q      <= '0;
                        k_q        <= '0;
                        checksum_q <= '0;
                        state_q    <= LOAD;
                    end
                end
                LOAD: if (accept) begin
                    if (bus.s_last_i) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        wr_en_q    <= 1'b1;
                        wr_addr_q  <= addr_d;
                        wr_data_q  <= bus.s_data_i;
                        checksum_q <= checksum_d;
                        if (k_q == KW'(p)) begin
                            k_q   <= '0;
                            seg_q <= seg_q + 1'b1;
                            if (&seg_q) state_q <= CHECK;
                        end else k_q <= k_q + 1'b1;
                    end
                end
                CHECK: if (accept) begin
                    done_q  <= csum_ok;
                    err_q   <= !csum_ok;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
